// File: rtl/alu_share_arb_if.sv
// Requester and ALU-side signal bundle for the shared ALU arbiter.
// master = requesters plus ALU model; slave = arbiter/sequencer.
interface alu_share_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_opcode;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_b;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_result;
  logic                          rsp_overflow;
  logic                          rsp_timeout;
  logic                          busy;
  logic                          alu_reset_n;
  logic                          alu_opcode_valid;
  logic                          alu_opcode;
  logic [DATA_WIDTH-1:0]         alu_data;
  logic                          alu_done;
  logic [DATA_WIDTH-1:0]         alu_result;
  logic                          alu_overflow;

  modport master (
    output req, req_opcode, req_data_a, req_data_b, alu_done, alu_result, alu_overflow,
    input  gnt, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy,
           alu_reset_n, alu_opcode_valid, alu_opcode, alu_data
  );

  modport slave (
    input  req, req_opcode, req_data_a, req_data_b, alu_done, alu_result, alu_overflow,
    output gnt, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy,
           alu_reset_n, alu_opcode_valid, alu_opcode, alu_data
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one ALU: gnt, A beat, B beat, wait for done (timeout), response; >=5 cycles gnt-to-gnt.
// One transaction in flight; requesters hold req until gnt, a timeout resets the ALU for RECOVER_CYC cycles.
module alu_share_arb #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT     = 16,
  parameter int RECOVER_CYC = 2
) (
  input logic            i_clk,
  input logic            i_reset,
  alu_share_arb_if.slave bus
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > RECOVER_CYC) ? TIMEOUT : RECOVER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP, S_RECOVER
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic [NUM_REQ-1:0]    r_win_oh, w_win_oh_nxt;

  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_result, w_rsp_result_nxt;
  logic                  r_rsp_overflow, w_rsp_overflow_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_alu_reset_n, w_alu_reset_n_nxt;
  logic                  r_alu_opcode_valid, w_alu_opcode_valid_nxt;
  logic                  r_alu_opcode, w_alu_opcode_nxt;
  logic [DATA_WIDTH-1:0] r_alu_data, w_alu_data_nxt;

  logic                  w_win_found;
  logic [NUM_REQ-1:0]    w_win_oh;
  logic [PTR_W-1:0]      w_win_ptr_nxt;
  logic                  w_win_op;
  logic [DATA_WIDTH-1:0] w_win_a;
  logic [DATA_WIDTH-1:0] w_win_b;

  // Pass 0 scans rr_ptr..NUM_REQ-1, pass 1 wraps to 0..rr_ptr-1.
  always_comb begin
    w_win_found   = 1'b0;
    w_win_oh      = '0;
    w_win_ptr_nxt = '0;
    w_win_op      = 1'b0;
    w_win_a       = '0;
    w_win_b       = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_win_found && bus.req[i] && ((p == 0) == (i >= int'(r_rr_ptr)))) begin
          w_win_found   = 1'b1;
          w_win_oh[i]   = 1'b1;
          w_win_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
          w_win_op      = bus.req_opcode[i];
          w_win_a       = bus.req_data_a[i*DATA_WIDTH +: DATA_WIDTH];
          w_win_b       = bus.req_data_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Output registers are loaded on the transition into each state, so they line up with it.
  always_comb begin
    w_state_nxt            = r_state;
    w_rr_ptr_nxt           = r_rr_ptr;
    w_cnt_nxt              = r_cnt;
    w_op_b_nxt             = r_op_b;
    w_win_oh_nxt           = r_win_oh;
    w_gnt_nxt              = '0;
    w_rsp_valid_nxt        = '0;
    w_rsp_result_nxt       = '0;
    w_rsp_overflow_nxt     = 1'b0;
    w_rsp_timeout_nxt      = 1'b0;
    w_alu_reset_n_nxt      = 1'b1;
    w_alu_opcode_valid_nxt = 1'b0;
    w_alu_opcode_nxt       = 1'b0;
    w_alu_data_nxt         = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_gnt_nxt              = w_win_oh;
          w_win_oh_nxt           = w_win_oh;
          w_rr_ptr_nxt           = w_win_ptr_nxt;
          w_op_b_nxt             = w_win_b;
          w_alu_opcode_valid_nxt = 1'b1;
          w_alu_opcode_nxt       = w_win_op;
          w_alu_data_nxt         = w_win_a;
          w_state_nxt            = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        w_alu_data_nxt = r_op_b;
        w_state_nxt    = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (bus.alu_done) begin
          w_rsp_valid_nxt    = r_win_oh;
          w_rsp_result_nxt   = bus.alu_result;
          w_rsp_overflow_nxt = bus.alu_overflow;
          w_state_nxt        = S_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rsp_valid_nxt   = r_win_oh;
          w_rsp_timeout_nxt = 1'b1;
          w_state_nxt       = S_RESP;
        end
      end
      S_RESP: begin
        if (r_rsp_timeout) begin
          w_cnt_nxt         = '0;
          w_alu_reset_n_nxt = 1'b0;
          w_state_nxt       = S_RECOVER;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECOVER: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(RECOVER_CYC - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_alu_reset_n_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_rr_ptr           <= '0;
      r_cnt              <= '0;
      r_op_b             <= '0;
      r_win_oh           <= '0;
      r_gnt              <= '0;
      r_rsp_valid        <= '0;
      r_rsp_result       <= '0;
      r_rsp_overflow     <= 1'b0;
      r_rsp_timeout      <= 1'b0;
      r_busy             <= 1'b0;
      r_alu_reset_n      <= 1'b0;
      r_alu_opcode_valid <= 1'b0;
      r_alu_opcode       <= 1'b0;
      r_alu_data         <= '0;
    end else begin
      r_state            <= w_state_nxt;
      r_rr_ptr           <= w_rr_ptr_nxt;
      r_cnt              <= w_cnt_nxt;
      r_op_b             <= w_op_b_nxt;
      r_win_oh           <= w_win_oh_nxt;
      r_gnt              <= w_gnt_nxt;
      r_rsp_valid        <= w_rsp_valid_nxt;
      r_rsp_result       <= w_rsp_result_nxt;
      r_rsp_overflow     <= w_rsp_overflow_nxt;
      r_rsp_timeout      <= w_rsp_timeout_nxt;
      r_busy             <= w_busy_nxt;
      r_alu_reset_n      <= w_alu_reset_n_nxt;
      r_alu_opcode_valid <= w_alu_opcode_valid_nxt;
      r_alu_opcode       <= w_alu_opcode_nxt;
      r_alu_data         <= w_alu_data_nxt;
    end
  end

  assign bus.gnt              = r_gnt;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_result       = r_rsp_result;
  assign bus.rsp_overflow     = r_rsp_overflow;
  assign bus.rsp_timeout      = r_rsp_timeout;
  assign bus.busy             = r_busy;
  assign bus.alu_reset_n      = r_alu_reset_n;
  assign bus.alu_opcode_valid = r_alu_opcode_valid;
  assign bus.alu_opcode       = r_alu_opcode;
  assign bus.alu_data         = r_alu_data;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
// The bench plays the ALU itself, asserting done on a chosen WAIT cycle with hand-picked result values.
module tb_alu_share_arb;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int RC = 2;

  typedef struct packed {
    logic [NR-1:0] vld;
    logic [DW-1:0] res;
    logic          ovf;
    logic          tmo;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [NR-1:0] gnt_q[$];
  rsp_t          rsp_q[$];
  logic [NR-1:0] mon_gnt;
  rsp_t          mon_rsp;

  logic [DW-1:0] a_tab[NR];
  logic [DW-1:0] b_tab[NR];
  logic [DW-1:0] r_tab[NR];
  logic          op_tab[NR];

  always #5 clk = ~clk;

  alu_share_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

  alu_share_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO), .RECOVER_CYC(RC)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int idx);
    logic [NR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic rsp_t mk_rsp(input int idx, input logic [DW-1:0] res, input logic ovf, input logic tmo);
    rsp_t e;
    e.vld = oh(idx);
    e.res = res;
    e.ovf = ovf;
    e.tmo = tmo;
    return e;
  endfunction

  // Monitor: every grant and response pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.gnt != '0) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
      else begin
        mon_gnt = gnt_q.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(mon_gnt));
      end
    end
    if (bus.rsp_valid != '0) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      else begin
        mon_rsp = rsp_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(mon_rsp.vld));
        chk("rsp_result", 32'(bus.rsp_result), 32'(mon_rsp.res));
        chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(mon_rsp.ovf));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(mon_rsp.tmo));
      end
    end
  end

  task automatic set_req(input int i, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req[i]                = 1'b1;
    bus.req_opcode[i]         = op;
    bus.req_data_a[i*DW +: DW] = a;
    bus.req_data_b[i*DW +: DW] = b;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        for (int j = 0; j < NR; j++) if (bus.gnt[j]) idx = j;
        break;
      end
    end
    if (idx < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_wait: no grant within 60 cycles, required one");
    end
  endtask

  // Called at the negedge of the grant (LOAD_A) cycle; delay<0 means the ALU never answers.
  task automatic serve(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int delay,
                       input logic [DW-1:0] res, input logic ovf, input logic exp_to);
    int   k;
    int   exp_k;
    logic got;
    chk("load_a_vld", 32'(bus.alu_opcode_valid), 32'd1);
    chk("load_a_op", 32'(bus.alu_opcode), 32'(op));
    chk("load_a_dat", 32'(bus.alu_data), 32'(a));
    @(negedge clk);
    chk("load_b_vld", 32'(bus.alu_opcode_valid), 32'd0);
    chk("load_b_dat", 32'(bus.alu_data), 32'(b));
    exp_k = (delay >= 0 && delay < TO) ? delay + 1 : TO;
    k     = 0;
    got   = 1'b0;
    while (!got && k <= 40) begin
      @(negedge clk);
      bus.alu_done     = 1'b0;
      bus.alu_result   = 8'hEE;
      bus.alu_overflow = 1'b0;
      if (k == 0) chk("wait_dat", 32'(bus.alu_data), 32'd0);
      if (bus.rsp_valid != '0) got = 1'b1;
      else begin
        if (k == delay) begin
          bus.alu_done     = 1'b1;
          bus.alu_result   = res;
          bus.alu_overflow = ovf;
        end
        k++;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_wait: no response within 40 WAIT cycles, required at cycle %0d", exp_k);
    end else begin
      chk("rsp_cycle", 32'(k), 32'(exp_k));
      chk("resp_busy", 32'(bus.busy), 32'd1);
    end
    if (exp_to) begin
      @(negedge clk);
      chk("recover_rstn_0", 32'(bus.alu_reset_n), 32'd0);
      @(negedge clk);
      chk("recover_rstn_1", 32'(bus.alu_reset_n), 32'd0);
    end
    @(negedge clk);
    chk("idle_rstn", 32'(bus.alu_reset_n), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset            = 1'b1;
    bus.req          = '0;
    bus.req_opcode   = '0;
    bus.req_data_a   = '0;
    bus.req_data_b   = '0;
    bus.alu_done     = 1'b0;
    bus.alu_result   = '0;
    bus.alu_overflow = 1'b0;
    a_tab  = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_tab  = '{8'h05, 8'h06, 8'h07, 8'h08};
    r_tab  = '{8'h16, 8'h28, 8'h3A, 8'h4C};
    op_tab = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rstn", 32'(bus.alu_reset_n), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_opv", 32'(bus.alu_opcode_valid), 32'd0);
    chk("rst_data", 32'(bus.alu_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rstn", 32'(bus.alu_reset_n), 32'd1);

    // Round-robin with all requests held: 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_req(i, op_tab[i], a_tab[i], b_tab[i]);
    for (int n = 0; n < 5; n++) gnt_q.push_back(oh(n % NR));
    for (int n = 0; n < 5; n++) begin
      wait_gnt(w);
      if (n == 4) bus.req = '0;
      rsp_q.push_back(mk_rsp(n % NR, r_tab[n % NR], 1'b0, 1'b0));
      serve(op_tab[n % NR], a_tab[n % NR], b_tab[n % NR], 1, r_tab[n % NR], 1'b0, 1'b0);
    end

    // Single requester, done three cycles after LOAD_B
    set_req(2, 1'b1, 8'h3C, 8'h05);
    gnt_q.push_back(4'b0100);
    rsp_q.push_back(mk_rsp(2, 8'h41, 1'b0, 1'b0));
    wait_gnt(w);
    bus.req = '0;
    serve(1'b1, 8'h3C, 8'h05, 2, 8'h41, 1'b0, 1'b0);

    // Overflow passthrough
    set_req(1, 1'b0, 8'hF0, 8'h20);
    gnt_q.push_back(4'b0010);
    rsp_q.push_back(mk_rsp(1, 8'h10, 1'b1, 1'b0));
    wait_gnt(w);
    bus.req = '0;
    serve(1'b0, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b0);

    // Timeout with requester 0 pending behind it
    set_req(3, 1'b0, 8'h7F, 8'h01);
    gnt_q.push_back(4'b1000);
    rsp_q.push_back(mk_rsp(3, 8'h00, 1'b0, 1'b1));
    wait_gnt(w);
    bus.req = '0;
    set_req(0, 1'b1, 8'h0A, 8'h0B);
    gnt_q.push_back(4'b0001);
    serve(1'b0, 8'h7F, 8'h01, -1, 8'h00, 1'b0, 1'b1);
    wait_gnt(w);
    bus.req = '0;
    rsp_q.push_back(mk_rsp(0, 8'h15, 1'b0, 1'b0));
    serve(1'b1, 8'h0A, 8'h0B, 1, 8'h15, 1'b0, 1'b0);

    // Done on the last WAIT cycle wins over the timeout
    set_req(2, 1'b0, 8'h55, 8'hAA);
    gnt_q.push_back(4'b0100);
    rsp_q.push_back(mk_rsp(2, 8'hFF, 1'b1, 1'b0));
    wait_gnt(w);
    bus.req = '0;
    serve(1'b0, 8'h55, 8'hAA, TO - 1, 8'hFF, 1'b1, 1'b0);

    // Reset mid-WAIT: no response, pointer back to 0
    set_req(1, 1'b1, 8'h12, 8'h34);
    gnt_q.push_back(4'b0010);
    wait_gnt(w);
    bus.req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rstn", 32'(bus.alu_reset_n), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_data", 32'(bus.alu_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rstn_after", 32'(bus.alu_reset_n), 32'd1);
    set_req(1, 1'b1, 8'h21, 8'h02);
    set_req(3, 1'b0, 8'h30, 8'h03);
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b1000);
    wait_gnt(w);
    bus.req[1] = 1'b0;
    rsp_q.push_back(mk_rsp(1, 8'h23, 1'b0, 1'b0));
    serve(1'b1, 8'h21, 8'h02, 0, 8'h23, 1'b0, 1'b0);
    wait_gnt(w);
    bus.req = '0;
    rsp_q.push_back(mk_rsp(3, 8'h33, 1'b0, 1'b0));
    serve(1'b0, 8'h30, 8'h03, 1, 8'h33, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
    chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one simple_alu instance among NUM_REQ requesters.
- Latches the winning requester's opcode and two operands, then drives the two-cycle ALU load sequence.
- Waits for ALU done, with a timeout, and returns result/overflow to the winner.
- On timeout it resets the ALU and recovers. Sits between requester agents and the ALU in the top-level bench.

Parameters:
- DATA_WIDTH, 8, width of operands, ALU data and result.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles in WAIT before declaring the ALU hung (>=2).
- RECOVER_CYC, 2, cycles alu_reset_n is held low after a timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until gnt.
- req_opcode  in  NUM_REQ  per-requester 1-bit ALU opcode.
- req_data_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_data_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; operands sampled this cycle.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse to the granted requester.
- rsp_result  out  DATA_WIDTH  result, valid with rsp_valid.
- rsp_overflow  out  1  ALU overflow, valid with rsp_valid.
- rsp_timeout  out  1  transaction aborted, valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- alu_reset_n  out  1  ALU active-low reset.
- alu_opcode_valid  out  1  ALU opcode strobe.
- alu_opcode  out  1  ALU opcode.
- alu_data  out  DATA_WIDTH  ALU operand bus.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  DATA_WIDTH  ALU result, valid with alu_done.
- alu_overflow  in  1  ALU overflow, valid with alu_done.

Behaviour:
- All outputs are registered.
- Reset values:
  - alu_reset_n=0 during reset, 1 on the first cycle after reset.
  - gnt, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, alu_opcode_valid, alu_opcode, alu_data = 0.
  - busy=0, state=IDLE, rr pointer=0, timeout counter=0.
- Reset asserted in any state aborts the transaction at the next edge; no rsp_valid is issued.
- IDLE:
  - If req!=0, select the first set bit scanning from rr_ptr upward with wrap.
  - Pulse gnt[w] and latch opcode/A/B of w at that edge.
  - Set rr_ptr=(w+1) mod NUM_REQ and go to LOAD_A.
  - A req dropped before it is granted is never granted.
- LOAD_A (1 cycle): alu_opcode_valid=1, alu_opcode=latched op, alu_data=A. Next state LOAD_B.
- LOAD_B (1 cycle): alu_opcode_valid=0, alu_opcode=0, alu_data=B. Next state WAIT, clearing the counter.
- WAIT:
  - alu_data=0; the counter increments each cycle.
  - On alu_done: capture alu_result/alu_overflow and go to RESP.
  - If the counter reaches TIMEOUT-1 without done: set result=0, overflow=0, timeout=1 and go to RESP.
  - If done and the timeout occur in the same cycle, done wins and timeout=0.
- RESP (1 cycle): drive rsp_valid[w]=1 with rsp_result/overflow/timeout. Then go to RECOVER if timeout, else IDLE. rsp_* return to 0 the following cycle.
- RECOVER: alu_reset_n=0 for RECOVER_CYC cycles, then 1; go to IDLE.
- alu_done outside WAIT is ignored.
- Arbitration throughput: at most one transaction in flight; minimum 5 cycles from gnt to the next possible gnt (gnt, LOAD_A, LOAD_B, WAIT>=1, RESP).
- Fairness: with all req held high, grants rotate 0,1,2,3,0,...
- rsp_valid reaches the requester 1 cycle after alu_done is sampled.

Test Plan:
- Single requester: req[2]=1, op=1, A=8'h3C, B=8'h05; ALU returns done 3 cycles after LOAD_B with result 8'h41 -> gnt=4'b0100 once; ALU sees valid/op=1/data=3C then data=05; rsp_valid=4'b0100 with rsp_result=41, rsp_overflow=0, rsp_timeout=0.
- Round-robin: req=4'b1111 held, each op completing in 2 cycles -> grant order 0,1,2,3,0; no requester granted twice before all others are granted.
- Overflow: A=8'hF0, B=8'h20, ALU done with result 8'h10 and overflow=1 -> rsp_overflow=1 and rsp_result=10 on the rsp_valid cycle.
- Timeout: ALU never asserts done, TIMEOUT=16 -> rsp_valid with rsp_timeout=1 and rsp_result=0 exactly 16 cycles after entering WAIT; alu_reset_n low 2 cycles; next pending req is granted afterwards.
- Done on the timeout cycle: alu_done=1 in WAIT cycle 15 -> rsp_timeout=0, result captured, no RECOVER.
- Reset mid-WAIT: assert reset for 1 cycle -> all outputs go to reset values; no rsp_valid; rr_ptr=0; alu_reset_n low during reset.
